// File: rtl/prom_func_gen_if.sv
// Bus bundle for prom_func_gen: read port, program port and status flags.
// The master drives requests; the slave (the PROM) returns data and status.
interface prom_func_gen_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned FUNC_N = 2
);
  logic              en;
  logic [ADDR_W-1:0] A;
  logic [FUNC_N-1:0] F;
  logic              rd_valid;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [FUNC_N-1:0] prog_data;
  logic              lock;
  logic              prog_busy;
  logic              prog_done;
  logic              prog_err;
  logic              locked;

  modport master (
    output en, A, prog_we, prog_addr, prog_data, lock,
    input  F, rd_valid, prog_busy, prog_done, prog_err, locked
  );

  modport slave (
    input  en, A, prog_we, prog_addr, prog_data, lock,
    output F, rd_valid, prog_busy, prog_done, prog_err, locked
  );
endinterface

// File: rtl/prom_func_gen.sv
// PROM-based multi-output function generator: registered truth-table lookup
// with one-time-programmable (fuse-OR) word writes, a timed burn and a sticky lock.
module prom_func_gen #(
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned FUNC_N   = 2,
  parameter int unsigned PROG_CYC = 4,
  parameter logic [FUNC_N*(2**ADDR_W)-1:0] INIT = 8'hD4
) (
  input logic              clk,
  input logic              rst_n,
  prom_func_gen_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(PROG_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PROG_CYC - 1);

  typedef enum logic {
    S_IDLE,
    S_BURN
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [FUNC_N-1:0]             data_q, data_d;
  logic [DEPTH-1:0][FUNC_N-1:0]  fuse_q, fuse_d;
  logic [FUNC_N-1:0]             f_q, f_d;
  logic                          rd_valid_q, rd_valid_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          locked_q, locked_d;

  // Next-state, fuse commit and read lookup; reads always see the pre-commit array.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    fuse_d     = fuse_q;
    f_d        = '0;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    locked_d   = locked_q | bus.lock;

    if (bus.en) begin
      f_d        = fuse_q[bus.A];
      rd_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.prog_we) begin
          // A lock arriving in the same cycle already blocks the request.
          if (locked_q || bus.lock) begin
            err_d = 1'b1;
          end else begin
            addr_d  = bus.prog_addr;
            data_d  = bus.prog_data;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_BURN;
          end
        end
      end
      S_BURN: begin
        if (bus.prog_we) begin
          err_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          fuse_d[addr_q] = fuse_q[addr_q] | data_q;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          state_d        = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      fuse_q     <= INIT;
      f_q        <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      fuse_q     <= fuse_d;
      f_q        <= f_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
    end
  end

  assign bus.F         = f_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.prog_busy = busy_q;
  assign bus.prog_done = done_q;
  assign bus.prog_err  = err_q;
  assign bus.locked    = locked_q;

endmodule

// File: tb/tb_prom_func_gen.sv
// Self-checking bench for prom_func_gen: scoreboarded reads against a fuse-array
// model, burn timing, OR-only programming, rejection, lock and async reset.
module tb_prom_func_gen;

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned FUNC_N   = 2;
  localparam int unsigned PROG_CYC = 4;
  localparam logic [7:0]  INIT     = 8'hD4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [FUNC_N-1:0] mdl [4];
  logic [FUNC_N-1:0] exp_q [$];

  prom_func_gen_if #(.ADDR_W(ADDR_W), .FUNC_N(FUNC_N)) bus ();

  prom_func_gen #(
    .ADDR_W  (ADDR_W),
    .FUNC_N  (FUNC_N),
    .PROG_CYC(PROG_CYC),
    .INIT    (INIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.en        = 1'b0;
    bus.A         = '0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.lock      = 1'b0;
  endtask

  task automatic model_init();
    logic [7:0] img;
    img = INIT;
    for (int i = 0; i < 4; i++) mdl[i] = img[i*FUNC_N +: FUNC_N];
    exp_q.delete();
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    model_init();
    cycle();
  endtask

  // Drive a read and push the word the model says it must return.
  task automatic read_push(input logic [ADDR_W-1:0] a);
    bus.en = 1'b1;
    bus.A  = a;
    exp_q.push_back(mdl[a]);
  endtask

  // Scoreboard consumer: pop the oldest expected word and compare with F.
  task automatic sb_pop_read(input string name);
    logic [FUNC_N-1:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, F=%b", name, bus.F);
    end else begin
      e = exp_q.pop_front();
      if (bus.F !== e || bus.rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s: F=%b rd_valid=%b, expected F=%b rd_valid=1",
                 name, bus.F, bus.rd_valid, e);
      end
    end
  endtask

  task automatic start_burn(input logic [ADDR_W-1:0] a, input logic [FUNC_N-1:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    cycle();
    bus.prog_we   = 1'b0;
  endtask

  // Run until the commit pulse; returns busy cycles seen and error pulses in flight.
  task automatic finish_burn(output int busy_cnt, output int err_cnt, output bit done_seen);
    busy_cnt  = int'(bus.prog_busy);
    err_cnt   = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      busy_cnt += int'(bus.prog_busy);
      err_cnt  += int'(bus.prog_err);
      if (bus.prog_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({bus.F, bus.rd_valid, bus.prog_busy, bus.prog_done, bus.prog_err, bus.locked} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: F=%b rd_valid=%b busy=%b done=%b err=%b locked=%b, expected all 0",
               bus.F, bus.rd_valid, bus.prog_busy, bus.prog_done, bus.prog_err, bus.locked);
    end
    #10;
    rst_n = 1'b1;
    model_init();
    cycle();
  endtask

  task automatic test_read();
    for (int a = 0; a < 4; a++) begin
      read_push(ADDR_W'(a));
      cycle();
      sb_pop_read($sformatf("read_a%0d", a));
    end
    bus.en = 1'b0;
    cycle();
    n_tests++;
    if (bus.F !== 2'b00 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_disable: F=%b rd_valid=%b, expected F=00 rd_valid=0", bus.F, bus.rd_valid);
    end
  endtask

  task automatic test_program();
    int busy_cnt;
    bit done_seen;
    busy_cnt  = 0;
    done_seen = 1'b0;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'd0;
    bus.prog_data = 2'b10;
    read_push(2'd0);
    cycle();
    bus.prog_we = 1'b0;
    sb_pop_read("prog_accept_read");
    busy_cnt = int'(bus.prog_busy);
    // Reads of the target during the burn, including at the commit edge, see the old word.
    for (int i = 0; i < 20; i++) begin
      read_push(2'd0);
      cycle();
      sb_pop_read("prog_read_during_burn");
      busy_cnt += int'(bus.prog_busy);
      if (bus.prog_done === 1'b1) begin
        done_seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL prog_done_timeout: prog_done=0 after 20 cycles, expected a pulse");
    end
    n_tests++;
    if (busy_cnt != PROG_CYC) begin
      n_fail++;
      $display("FAIL prog_busy_len: busy cycles=%0d, expected %0d", busy_cnt, PROG_CYC);
    end
    mdl[0] = mdl[0] | 2'b10;
    read_push(2'd0);
    cycle();
    sb_pop_read("prog_read_after_commit");
    n_tests++;
    if (bus.prog_done !== 1'b0 || bus.prog_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_done_pulse: done=%b busy=%b one cycle after commit, expected 0 0",
               bus.prog_done, bus.prog_busy);
    end
    bus.en = 1'b0;
  endtask

  task automatic test_or();
    int busy_cnt, err_cnt;
    bit done_seen;
    start_burn(2'd3, 2'b00);
    finish_burn(busy_cnt, err_cnt, done_seen);
    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL or_burn3_done: no prog_done, expected a pulse");
    end
    mdl[3] = mdl[3] | 2'b00;
    start_burn(2'd1, 2'b10);
    finish_burn(busy_cnt, err_cnt, done_seen);
    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL or_burn1_done: no prog_done, expected a pulse");
    end
    mdl[1] = mdl[1] | 2'b10;
    read_push(2'd3);
    cycle();
    sb_pop_read("or_word3");
    read_push(2'd1);
    cycle();
    sb_pop_read("or_word1");
    bus.en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int busy_cnt, err_cnt;
    bit done_seen;
    start_burn(2'd0, 2'b01);
    cycle();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'd2;
    bus.prog_data = 2'b10;
    cycle();
    bus.prog_we = 1'b0;
    n_tests++;
    if (bus.prog_err !== 1'b1 || bus.prog_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_reject: err=%b busy=%b, expected err=1 busy=1", bus.prog_err, bus.prog_busy);
    end
    finish_burn(busy_cnt, err_cnt, done_seen);
    n_tests++;
    if (!done_seen || err_cnt != 0) begin
      n_fail++;
      $display("FAIL b2b_first_done: done=%0b extra err pulses=%0d, expected done=1 err=0",
               done_seen, err_cnt);
    end
    mdl[0] = mdl[0] | 2'b01;
    // Request in the prog_done cycle is accepted.
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'd2;
    bus.prog_data = 2'b00;
    cycle();
    bus.prog_we = 1'b0;
    n_tests++;
    if (bus.prog_busy !== 1'b1 || bus.prog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b err=%b, expected busy=1 err=0", bus.prog_busy, bus.prog_err);
    end
    finish_burn(busy_cnt, err_cnt, done_seen);
    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL b2b_second_done: no prog_done, expected a pulse");
    end
    read_push(2'd0);
    cycle();
    sb_pop_read("b2b_word0");
    read_push(2'd2);
    cycle();
    sb_pop_read("b2b_word2_unchanged");
    bus.en = 1'b0;
  endtask

  task automatic test_lock();
    int busy_cnt, err_cnt;
    bit done_seen;
    apply_reset();
    bus.lock      = 1'b1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'd2;
    bus.prog_data = 2'b10;
    cycle();
    bus.lock    = 1'b0;
    bus.prog_we = 1'b0;
    n_tests++;
    if (bus.prog_err !== 1'b1 || bus.prog_busy !== 1'b0 || bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_same_cycle: err=%b busy=%b locked=%b, expected 1 0 1",
               bus.prog_err, bus.prog_busy, bus.locked);
    end
    cycle();
    n_tests++;
    if (bus.prog_err !== 1'b0 || bus.locked !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_sticky: err=%b locked=%b, expected 0 1", bus.prog_err, bus.locked);
    end
    bus.prog_we   = 1'b1;
    bus.prog_addr = 2'd0;
    bus.prog_data = 2'b11;
    cycle();
    bus.prog_we = 1'b0;
    n_tests++;
    if (bus.prog_err !== 1'b1 || bus.prog_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_reject: err=%b busy=%b, expected 1 0", bus.prog_err, bus.prog_busy);
    end
    for (int i = 0; i < PROG_CYC + 2; i++) cycle();
    read_push(2'd2);
    cycle();
    sb_pop_read("lock_word2_unchanged");
    read_push(2'd0);
    cycle();
    sb_pop_read("lock_word0_unchanged");
    bus.en = 1'b0;
    n_tests++;
    if (bus.locked !== 1'b1 || bus.prog_done !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_persist: locked=%b done=%b, expected 1 0", bus.locked, bus.prog_done);
    end

    apply_reset();
    start_burn(2'd0, 2'b10);
    bus.lock = 1'b1;
    cycle();
    bus.lock = 1'b0;
    n_tests++;
    if (bus.locked !== 1'b1 || bus.prog_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_in_burn: locked=%b busy=%b, expected 1 1", bus.locked, bus.prog_busy);
    end
    finish_burn(busy_cnt, err_cnt, done_seen);
    n_tests++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL lock_in_burn_done: no prog_done, expected a pulse");
    end
    mdl[0] = mdl[0] | 2'b10;
    read_push(2'd0);
    cycle();
    sb_pop_read("lock_in_burn_commit");
    bus.en = 1'b0;
  endtask

  task automatic test_reset_mid_burn();
    int done_cnt;
    apply_reset();
    bus.en = 1'b1;
    bus.A  = 2'd1;
    start_burn(2'd0, 2'b11);
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.F, bus.rd_valid, bus.prog_busy, bus.prog_done, bus.prog_err, bus.locked} !== 7'b0) begin
      n_fail++;
      $display("FAIL async_reset: F=%b rd_valid=%b busy=%b done=%b err=%b locked=%b, expected all 0",
               bus.F, bus.rd_valid, bus.prog_busy, bus.prog_done, bus.prog_err, bus.locked);
    end
    bus.en = 1'b0;
    #10;
    rst_n = 1'b1;
    model_init();
    done_cnt = 0;
    for (int i = 0; i < PROG_CYC + 2; i++) begin
      cycle();
      done_cnt += int'(bus.prog_done) + int'(bus.prog_busy);
    end
    n_tests++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_no_commit: done/busy activity=%0d after reset, expected 0", done_cnt);
    end
    read_push(2'd0);
    cycle();
    sb_pop_read("abort_word0_init");
    bus.en = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_read();
    test_program();
    test_or();
    test_back_to_back();
    test_lock();
    test_reset_mid_burn();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
